// File: rtl/max_score_tracker.sv
// max_score_tracker: running maximum of PE scores across a streamed alignment.
//
// Scores arrive one beat per valid_in cycle as a flat [pu][row][col] vector.
// Stage 1 picks the best PE inside each PU, and stage 2 reduces across PUs
// into the running maximum. A beat's effect is therefore visible two cycles
// after it is presented.
//
// Build option:
//   MAX_TRACK_COORD_EN - when defined, also track the row/column of the
//                        maximum. When undefined, max_row/max_col read 0 and
//                        no coordinate state is built.
module max_score_tracker #(
  parameter int unsigned NUM_PU      = 4,
  parameter int unsigned NUM_ROWS_PE = 2,
  parameter int unsigned NUM_COLS_PE = 2,
  parameter int unsigned SCORE_WIDTH = 8,
  parameter int unsigned COORD_W     = 6
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 start,
  input  logic                                                 valid_in,
  input  logic                                                 last_in,
  input  logic [NUM_PU*NUM_ROWS_PE*NUM_COLS_PE*SCORE_WIDTH-1:0] scores_in,
  input  logic [NUM_PU*COORD_W-1:0]                            row_base,
  input  logic [NUM_PU*COORD_W-1:0]                            col_base,
  input  logic [NUM_PU-1:0]                                    en_pu,
  output logic [SCORE_WIDTH-1:0]                               max_score,
  output logic [COORD_W-1:0]                                   max_row,
  output logic [COORD_W-1:0]                                   max_col,
  output logic                                                 busy,
  output logic                                                 done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StTrack = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0] state_q, state_d;
  logic       drain_cnt_q, drain_cnt_d;
  logic       beat_accept;

  // Beats are only taken while tracking; a start in the same cycle wins.
  assign beat_accept = (state_q == StTrack) && valid_in && !start;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // Next-state: start restarts from any state; DRAIN lasts exactly two cycles.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (start) begin
      state_d     = StTrack;
      drain_cnt_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StTrack: begin
          if (valid_in && last_in) begin
            state_d     = StDrain;
            drain_cnt_d = 1'b0;
          end
        end
        StDrain: begin
          if (drain_cnt_q) begin
            state_d = StDone;
          end else begin
            drain_cnt_d = 1'b1;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      drain_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign busy = (state_q == StTrack) || (state_q == StDrain);
  assign done = (state_q == StDone);

  // ---------------------------------------------------------------------------
  // Stage 1: best PE per PU
  // ---------------------------------------------------------------------------
  logic [SCORE_WIDTH-1:0] pu_score   [NUM_PU];
  logic [SCORE_WIDTH-1:0] s1_score_q [NUM_PU];
  logic                   s1_valid_q;

`ifdef MAX_TRACK_COORD_EN
  logic [COORD_W-1:0] pu_row   [NUM_PU];
  logic [COORD_W-1:0] pu_col   [NUM_PU];
  logic [COORD_W-1:0] s1_row_q [NUM_PU];
  logic [COORD_W-1:0] s1_col_q [NUM_PU];

  // Row-major scan with strict '>' keeps the lowest row, then lowest col, on ties.
  // Coordinates wrap modulo 2^COORD_W.
  always_comb begin
    for (int p = 0; p < NUM_PU; p++) begin
      pu_score[p] = '0;
      pu_row[p]   = row_base[p*COORD_W +: COORD_W];
      pu_col[p]   = col_base[p*COORD_W +: COORD_W];
      if (en_pu[p]) begin
        for (int r = 0; r < NUM_ROWS_PE; r++) begin
          for (int c = 0; c < NUM_COLS_PE; c++) begin
            if (scores_in[((p*NUM_ROWS_PE + r)*NUM_COLS_PE + c)*SCORE_WIDTH +: SCORE_WIDTH]
                > pu_score[p]) begin
              pu_score[p] =
                  scores_in[((p*NUM_ROWS_PE + r)*NUM_COLS_PE + c)*SCORE_WIDTH +: SCORE_WIDTH];
              pu_row[p] = row_base[p*COORD_W +: COORD_W] + COORD_W'(r);
              pu_col[p] = col_base[p*COORD_W +: COORD_W] + COORD_W'(c);
            end
          end
        end
      end
    end
  end

  // Stage-1 coordinate registers; qualified by s1_valid_q, so no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && beat_accept) begin
      s1_row_q <= pu_row;
      s1_col_q <= pu_col;
    end
  end
`else
  logic unused_coords;
  assign unused_coords = ^{row_base, col_base};

  // Per-PU maximum score; masked PUs stay at 0.
  always_comb begin
    for (int p = 0; p < NUM_PU; p++) begin
      pu_score[p] = '0;
      if (en_pu[p]) begin
        for (int i = 0; i < NUM_ROWS_PE*NUM_COLS_PE; i++) begin
          if (scores_in[(p*NUM_ROWS_PE*NUM_COLS_PE + i)*SCORE_WIDTH +: SCORE_WIDTH]
              > pu_score[p]) begin
            pu_score[p] =
                scores_in[(p*NUM_ROWS_PE*NUM_COLS_PE + i)*SCORE_WIDTH +: SCORE_WIDTH];
          end
        end
      end
    end
  end
`endif

  // Stage-1 valid: rst and start both flush whatever is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= beat_accept;
    end
  end

  // Stage-1 score registers; qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    if (!rst && beat_accept) begin
      s1_score_q <= pu_score;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: reduce across PUs into the running maximum
  // ---------------------------------------------------------------------------
  logic [SCORE_WIDTH-1:0] cand_score;
  logic [SCORE_WIDTH-1:0] max_score_q;
  logic                   max_upd;
  logic                   max_clr;

`ifdef MAX_TRACK_COORD_EN
  logic [COORD_W-1:0] cand_row, cand_col;
  logic [COORD_W-1:0] max_row_q, max_col_q;

  // Ascending PU scan with strict '>' keeps the lowest PU index on ties.
  always_comb begin
    cand_score = s1_score_q[0];
    cand_row   = s1_row_q[0];
    cand_col   = s1_col_q[0];
    for (int p = 1; p < NUM_PU; p++) begin
      if (s1_score_q[p] > cand_score) begin
        cand_score = s1_score_q[p];
        cand_row   = s1_row_q[p];
        cand_col   = s1_col_q[p];
      end
    end
  end
`else
  // Ascending PU scan; only the score matters here.
  always_comb begin
    cand_score = s1_score_q[0];
    for (int p = 1; p < NUM_PU; p++) begin
      if (s1_score_q[p] > cand_score) begin
        cand_score = s1_score_q[p];
      end
    end
  end
`endif

  // Strict '>' so the earliest beat holding the maximum is retained.
  assign max_upd = s1_valid_q && (cand_score > max_score_q);
  assign max_clr = rst || start;

  // Running maximum score.
  always_ff @(posedge clk) begin
    if (max_clr) begin
      max_score_q <= '0;
    end else if (max_upd) begin
      max_score_q <= cand_score;
    end
  end

  assign max_score = max_score_q;

`ifdef MAX_TRACK_COORD_EN
  // Coordinates of the running maximum, updated together with the score.
  always_ff @(posedge clk) begin
    if (max_clr) begin
      max_row_q <= '0;
      max_col_q <= '0;
    end else if (max_upd) begin
      max_row_q <= cand_row;
      max_col_q <= cand_col;
    end
  end

  assign max_row = max_row_q;
  assign max_col = max_col_q;
`else
  assign max_row = '0;
  assign max_col = '0;
`endif

endmodule

// File: tb/tb_max_score_tracker.sv
// Testbench for max_score_tracker: directed scenarios plus random stimulus,
// checked every cycle against a beat-list reference model.
module tb_max_score_tracker;

  localparam int NPU = 4;
  localparam int NR  = 2;
  localparam int NC  = 2;
  localparam int SW  = 8;
  localparam int CW  = 6;
  localparam int NPE = NPU * NR * NC;

`ifdef MAX_TRACK_COORD_EN
  localparam bit CoordEn = 1'b1;
`else
  localparam bit CoordEn = 1'b0;
`endif

  localparam int PIdle  = 0;
  localparam int PTrack = 1;
  localparam int PDrain = 2;
  localparam int PDone  = 3;

  logic              clk = 1'b0;
  logic              rst, start, valid_in, last_in;
  logic [NPE*SW-1:0] scores_in;
  logic [NPU*CW-1:0] row_base, col_base;
  logic [NPU-1:0]    en_pu;
  logic [SW-1:0]     max_score;
  logic [CW-1:0]     max_row, max_col;
  logic              busy, done;

  always #5 clk = ~clk;

  max_score_tracker #(
    .NUM_PU      (NPU),
    .NUM_ROWS_PE (NR),
    .NUM_COLS_PE (NC),
    .SCORE_WIDTH (SW),
    .COORD_W     (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .valid_in  (valid_in),
    .last_in   (last_in),
    .scores_in (scores_in),
    .row_base  (row_base),
    .col_base  (col_base),
    .en_pu     (en_pu),
    .max_score (max_score),
    .max_row   (max_row),
    .max_col   (max_col),
    .busy      (busy),
    .done      (done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase, drain countdown, and every accepted beat's best
  // cell with the edge count at which it was accepted.
  int m_phase = PIdle;
  int m_left  = 0;
  int cyc     = 0;
  int bq_s[$];
  int bq_r[$];
  int bq_c[$];
  int bq_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pe_val(input int p, input int r, input int c);
    return int'(scores_in[((p*NR + r)*NC + c)*SW +: SW]);
  endfunction

  task automatic set_pe(input int p, input int r, input int c, input int v);
    scores_in[((p*NR + r)*NC + c)*SW +: SW] = SW'(v);
  endtask

  task automatic fill(input int maxv);
    for (int i = 0; i < NPE; i++) scores_in[i*SW +: SW] = SW'($urandom_range(0, maxv));
    for (int p = 0; p < NPU; p++) begin
      row_base[p*CW +: CW] = CW'($urandom);
      col_base[p*CW +: CW] = CW'($urandom);
    end
  endtask

  function automatic int wrap_add(input int base, input int off);
    return (base + off) % (1 << CW);
  endfunction

  // Best cell of the current beat: scan PU, row, col in order, first maximum wins.
  task automatic model_beat();
    int bs, br, bc, v;
    bs = 0; br = 0; bc = 0;
    for (int p = 0; p < NPU; p++)
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NC; c++) begin
          v = en_pu[p] ? pe_val(p, r, c) : 0;
          if (v > bs) begin
            bs = v;
            br = wrap_add(int'(row_base[p*CW +: CW]), r);
            bc = wrap_add(int'(col_base[p*CW +: CW]), c);
          end
        end
    bq_s.push_back(bs);
    bq_r.push_back(br);
    bq_c.push_back(bc);
    bq_t.push_back(cyc);
  endtask

  task automatic clear_beats();
    bq_s.delete(); bq_r.delete(); bq_c.delete(); bq_t.delete();
  endtask

  // Compare all outputs with the model; a beat shows up two cycles after it is driven.
  task automatic check_all();
    int es, er, ec;
    es = 0; er = 0; ec = 0;
    for (int i = 0; i < bq_s.size(); i++) begin
      if (bq_t[i] <= cyc - 1 && bq_s[i] > es) begin
        es = bq_s[i]; er = bq_r[i]; ec = bq_c[i];
      end
    end
    chk("max_score", 32'(max_score), 32'(es));
    chk("max_row", 32'(max_row), CoordEn ? 32'(er) : 32'd0);
    chk("max_col", 32'(max_col), CoordEn ? 32'(ec) : 32'd0);
    chk("busy", 32'(busy), 32'(m_phase == PTrack || m_phase == PDrain));
    chk("done", 32'(done), 32'(m_phase == PDone));
  endtask

  // One clock: drive controls, advance the model at the edge, check 1 time unit later.
  task automatic cycle(input bit s, input bit rs, input bit v, input bit l);
    start = s; rst = rs; valid_in = v; last_in = l;
    @(posedge clk);
    cyc++;
    if (rs) begin
      m_phase = PIdle;
      clear_beats();
    end else if (s) begin
      m_phase = PTrack;
      clear_beats();
    end else begin
      case (m_phase)
        PTrack: begin
          if (v) begin
            model_beat();
            if (l) begin
              m_phase = PDrain;
              m_left  = 2;
            end
          end
        end
        PDrain: begin
          m_left--;
          if (m_left == 0) m_phase = PDone;
        end
        default: ;
      endcase
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int er, ec;
    bit s, rs, v, l;
    rst = 1'b1; start = 1'b0; valid_in = 1'b0; last_in = 1'b0;
    scores_in = '0; row_base = '0; col_base = '0; en_pu = '1;

    // Reset state
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);

    // valid_in in IDLE is ignored
    fill(255);
    set_pe(1, 0, 0, 200);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Single beat: PU2 PE[1][0]=37 at base (4,2)
    fill(36);
    set_pe(2, 1, 0, 37);
    row_base[2*CW +: CW] = 4;
    col_base[2*CW +: CW] = 2;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s1_score_2cyc", 32'(max_score), 32'd37);
    chk("s1_done_early", 32'(done), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s1_done_3cyc", 32'(done), 32'd1);
    chk("s1_row", 32'(max_row), CoordEn ? 32'd5 : 32'd0);
    chk("s1_col", 32'(max_col), CoordEn ? 32'd2 : 32'd0);

    // valid_in in DONE is ignored, outputs hold
    fill(10);
    set_pe(0, 0, 0, 250);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    chk("done_hold", 32'(max_score), 32'd37);

    // Ties: PU0 PE[1][1] and PU1 PE[0][0] both 20, then 20 again later
    fill(19);
    set_pe(0, 1, 1, 20);
    set_pe(1, 0, 0, 20);
    er = wrap_add(int'(row_base[0 +: CW]), 1);
    ec = wrap_add(int'(col_base[0 +: CW]), 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    fill(19);
    set_pe(0, 0, 0, 20);
    set_pe(3, 1, 0, 20);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    chk("tie_score", 32'(max_score), 32'd20);
    chk("tie_row", 32'(max_row), CoordEn ? 32'(er) : 32'd0);
    chk("tie_col", 32'(max_col), CoordEn ? 32'(ec) : 32'd0);

    // Masking: PU0 holds 99 but is disabled
    en_pu = 4'b1110;
    fill(9);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) set_pe(0, r, c, 99);
    set_pe(3, 1, 1, 10);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    chk("mask_score", 32'(max_score), 32'd10);
    en_pu = '1;

    // Restart mid-TRACK after 50; beat offered with start is ignored
    fill(40);
    set_pe(1, 0, 1, 50);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("restart_pre", 32'(max_score), 32'd50);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    fill(11);
    set_pe(2, 0, 0, 12);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    chk("restart_score", 32'(max_score), 32'd12);
    chk("restart_done", 32'(done), 32'd1);

    // Reset in DRAIN with 60 pending
    fill(30);
    set_pe(3, 1, 0, 60);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_score", 32'(max_score), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    idle(3);
    chk("rst_no60", 32'(max_score), 32'd0);

    // Coordinate wrap: row_base 63 + PE row 1 -> 0
    fill(20);
    row_base[0 +: CW] = 63;
    col_base[0 +: CW] = 7;
    set_pe(0, 1, 0, 200);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    chk("wrap_score", 32'(max_score), 32'd200);
    chk("wrap_row", 32'(max_row), 32'd0);
    chk("wrap_col", 32'(max_col), CoordEn ? 32'd7 : 32'd0);

    // start during DRAIN flushes the pending beat
    fill(100);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("drain_restart", 32'(max_score), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      fill((i % 3 == 0) ? 255 : 63);
      if ($urandom % 8 == 0) en_pu = NPU'($urandom);
      s  = ($urandom % 16) == 0;
      rs = ($urandom % 50) == 0;
      v  = (m_phase != PDrain) && ($urandom % 2 == 0);
      l  = ($urandom % 6) == 0;
      cycle(s, rs, v, l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/max_score_tracker.md
MAX_SCORE_TRACKER -- requirements
Module: max_score_tracker

Interface
REQ-001 SHALL have parameter NUM_PU, default 4, number of processing units feeding the block.
REQ-002 SHALL have parameter NUM_ROWS_PE, default 2, PE rows per PU.
REQ-003 SHALL have parameter NUM_COLS_PE, default 2, PE columns per PU.
REQ-004 SHALL have parameter SCORE_WIDTH, default 8, unsigned cell score width.
REQ-005 SHALL have parameter COORD_W, default 6, matrix row/column index width.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port start, input, 1, one-cycle pulse that begins a new alignment.
REQ-009 SHALL have port valid_in, input, 1, scores_in, row_base and col_base are valid this cycle.
REQ-010 SHALL have port last_in, input, 1, qualified by valid_in; marks the final score beat of the alignment.
REQ-011 SHALL have port scores_in, input, NUM_PU*NUM_ROWS_PE*NUM_COLS_PE*SCORE_WIDTH, registered PE scores indexed [pu][row][col].
REQ-012 SHALL have port row_base, input, NUM_PU*COORD_W, matrix row of PE[0][0] per PU.
REQ-013 SHALL have port col_base, input, NUM_PU*COORD_W, matrix column of PE[0][0] per PU.
REQ-014 SHALL have port en_pu, input, NUM_PU, per-PU active mask; masked PUs contribute score 0.
REQ-015 SHALL have port max_score, output, SCORE_WIDTH, running maximum score.
REQ-016 SHALL have ports max_row and max_col, output, COORD_W each, coordinates of max_score.
REQ-017 SHALL have port busy, output, 1, high in TRACK and DRAIN.
REQ-018 SHALL have port done, output, 1, high in DONE; results final.

Function
REQ-019 SHALL implement FSM IDLE, TRACK, DRAIN, DONE.
- IDLE->TRACK on start.
- TRACK->DRAIN on valid_in&&last_in.
- DRAIN->DONE after exactly 2 cycles.
- DONE->TRACK on start.
REQ-020 SHALL, on start in any state, clear max_score/max_row/max_col to 0, flush both pipeline stages, enter TRACK, and ignore valid_in in that same cycle.
REQ-021 SHALL ignore valid_in in IDLE and DONE.
REQ-022 SHALL implement stage 1 that registers, per PU, the maximum of its PEs plus the absolute coordinates (row_base+row, col_base+col), with a stage-1 valid bit.
REQ-023 SHALL implement stage 2 that reduces the stage-1 results across PUs and updates the running max only if the candidate is strictly greater than max_score.
REQ-024 SHALL give a beat's update at the outputs 2 cycles after its valid_in cycle.
REQ-025 SHALL break ties by lowest PU index, then lowest row, then lowest col; across beats, the earliest maximum is retained.
REQ-026 SHALL compute coordinate sums modulo 2^COORD_W (wrap, no saturation).
REQ-027 SHALL treat scores as unsigned; an all-zero alignment ends with max_score=0, max_row=0, max_col=0.
REQ-028 SHALL include pipelined beats in DRAIN so the final outputs include the last beat when done rises.
REQ-029 SHALL hold outputs stable in DONE until the next start.

Reset
REQ-030 SHALL, on rst high at a clock edge, enter IDLE and set max_score=0, max_row=0, max_col=0, busy=0, done=0, and clear all pipeline valids.
REQ-031 SHALL give rst priority over start and valid_in, and SHALL discard any in-flight beat when rst is asserted mid-alignment.

Configuration
REQ-032 SHALL, with macro MAX_TRACK_COORD_EN defined, track and output coordinates per REQ-016/022/025.
REQ-033 SHALL, without MAX_TRACK_COORD_EN, tie max_row and max_col to 0, omit coordinate registers, and leave score latency and FSM timing unchanged.

Verification
REQ-034 SHALL cover single beat: start; one beat with last_in, PU2 PE[1][0]=37, others <37, row_base[2]=4, col_base[2]=2 -> 2 cycles later max_score=37, max_row=5, max_col=2; done 3 cycles after the beat.
REQ-035 SHALL cover ties: PU0 PE[1][1] and PU1 PE[0][0] both 20 in one beat, then 20 again in a later beat -> max reports PU0 coordinates from the first beat.
REQ-036 SHALL cover masking: en_pu=4'b1110 with PU0 holding 99, others max 10 -> max_score=10.
REQ-037 SHALL cover restart: start mid-TRACK after max=50 is established, then a beat with max 12 and last_in -> done with max_score=12.
REQ-038 SHALL cover reset: rst in DRAIN with a pending 60 in the pipeline -> next cycle IDLE, all outputs 0, and 60 never appears.
REQ-039 SHALL cover wrap: COORD_W=6, row_base=63, PE row 1 wins -> max_row=0.
